// File: rtl/life_gen_ctrl_if.sv
// life_gen_ctrl_if
// Groups the key inputs, the run period and all sweep/status outputs of
// life_gen_ctrl into one bundle.
//   key_nxt, key_run : raw key levels. A key is released when it goes 1 -> 0.
//   period           : extra idle cycles between sweeps in run mode.
//   sweep_en         : the cell on cell_x/cell_y is to be updated this cycle.
//   cell_x, cell_y   : current cell coordinates.
//   cell_idx         : cell_y*X + cell_x.
//   last_cell        : the current swept cell is the final one.
//   gen_done         : one-cycle pulse after the final cell of a sweep.
//   gen_cnt          : completed generations, wraps at 2^GEN_W.
//   running          : run mode is active.
// Modports: master drives keys/period (the user side), slave is the controller.
interface life_gen_ctrl_if #(
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3,
    parameter int GEN_W = 16,
    parameter int PER_W = 24
);
    logic                   key_nxt;
    logic                   key_run;
    logic [PER_W-1:0]       period;
    logic                   sweep_en;
    logic [LOG2X-1:0]       cell_x;
    logic [LOG2Y-1:0]       cell_y;
    logic [LOG2X+LOG2Y-1:0] cell_idx;
    logic                   last_cell;
    logic                   gen_done;
    logic [GEN_W-1:0]       gen_cnt;
    logic                   running;

    modport master (
        output key_nxt, key_run, period,
        input  sweep_en, cell_x, cell_y, cell_idx, last_cell, gen_done,
               gen_cnt, running
    );

    modport slave (
        input  key_nxt, key_run, period,
        output sweep_en, cell_x, cell_y, cell_idx, last_cell, gen_done,
               gen_cnt, running
    );
endinterface

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl
// Generation controller for a Game-of-Life grid of X by Y cells. It sweeps
// every cell once per generation in row-major order, raising sweep_en for
// exactly X*Y cycles, then pulses gen_done and bumps gen_cnt. Sweeps are
// started either by a step key (single generation) or continuously in run
// mode with a programmable idle gap of period+1 cycles between sweeps.
// Ports:
//   clk       : rising-edge clock.
//   reset     : synchronous, active-low.
//   bus       : life_gen_ctrl_if slave (keys, period, sweep/status outputs).
//   state_dbg : current FSM state (0 IDLE, 1 SWEEP, 2 WAIT).
// Key protocol: each key is registered once; a release is key_d=1 with key=0
// and is acted on in the very cycle it is seen. There is no back-pressure:
// a release that cannot be used (step while running) is simply dropped.
module life_gen_ctrl #(
    parameter int X     = 8,
    parameter int Y     = 8,
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3,
    parameter int GEN_W = 16,
    parameter int PER_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    life_gen_ctrl_if.slave      bus,
    output logic [1:0]          state_dbg
);
    localparam int IW = LOG2X + LOG2Y;
    localparam logic [LOG2X-1:0] X_LAST = LOG2X'(X - 1);
    localparam logic [LOG2Y-1:0] Y_LAST = LOG2Y'(Y - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_nx;
    logic             key_nxt_d, key_run_d;
    logic             pending_q, pending_nx;
    logic             running_q, running_nx;
    logic [LOG2X-1:0] x_q, x_nx;
    logic [LOG2Y-1:0] y_q, y_nx;
    logic [IW-1:0]    idx_q, idx_nx;
    logic             en_q, en_nx;
    logic             last_q, last_nx;
    logic             done_q, done_nx;
    logic [GEN_W-1:0] gen_q, gen_nx;
    logic [PER_W-1:0] wait_q, wait_nx;

    logic step_rel, run_rel, step_ok, run_on;

    always_comb begin
        step_rel = key_nxt_d & ~bus.key_nxt;
        run_rel  = key_run_d & ~bus.key_run;
        // A run release wins over a simultaneous step, and steps are ignored
        // while running.
        step_ok  = step_rel & ~run_rel & ~running_q;
        run_on   = run_rel & ~running_q;
    end

    always_comb begin
        state_nx   = state_q;
        running_nx = running_q ^ run_rel;
        // Single-entry step latch; cleared whenever run mode is switched on
        // so a stale step cannot fire after run mode is left again.
        pending_nx = (pending_q | step_ok) & ~run_on;
        x_nx       = '0;
        y_nx       = '0;
        idx_nx     = '0;
        en_nx      = 1'b0;
        last_nx    = 1'b0;
        done_nx    = 1'b0;
        gen_nx     = gen_q;
        wait_nx    = wait_q;

        case (state_q)
            IDLE: begin
                if (run_on || step_ok) begin
                    state_nx   = SWEEP;
                    en_nx      = 1'b1;
                    pending_nx = 1'b0;
                end
            end
            SWEEP: begin
                if (last_q) begin
                    // The gen_done cycle is the first gap cycle; WAIT
                    // decides what follows it.
                    state_nx = WAIT;
                    done_nx  = 1'b1;
                    gen_nx   = gen_q + GEN_W'(1);
                    wait_nx  = bus.period;
                end else begin
                    en_nx  = 1'b1;
                    idx_nx = idx_q + IW'(1);
                    if (x_q == X_LAST) begin
                        x_nx = '0;
                        y_nx = y_q + LOG2Y'(1);
                    end else begin
                        x_nx = x_q + LOG2X'(1);
                        y_nx = y_q;
                    end
                    last_nx = (x_nx == X_LAST) && (y_nx == Y_LAST);
                end
            end
            WAIT: begin
                if (running_q && run_rel) begin
                    state_nx = IDLE;
                end else if (run_on) begin
                    state_nx   = SWEEP;
                    en_nx      = 1'b1;
                    pending_nx = 1'b0;
                end else if (running_q) begin
                    if (wait_q == '0) begin
                        state_nx = SWEEP;
                        en_nx    = 1'b1;
                    end else begin
                        wait_nx = wait_q - PER_W'(1);
                    end
                end else if (pending_q || step_ok) begin
                    state_nx   = SWEEP;
                    en_nx      = 1'b1;
                    pending_nx = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            key_nxt_d <= 1'b0;
            key_run_d <= 1'b0;
            pending_q <= 1'b0;
            running_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            en_q      <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            gen_q     <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_nx;
            key_nxt_d <= bus.key_nxt;
            key_run_d <= bus.key_run;
            pending_q <= pending_nx;
            running_q <= running_nx;
            x_q       <= x_nx;
            y_q       <= y_nx;
            idx_q     <= idx_nx;
            en_q      <= en_nx;
            last_q    <= last_nx;
            done_q    <= done_nx;
            gen_q     <= gen_nx;
            wait_q    <= wait_nx;
        end
    end

    assign bus.sweep_en  = en_q;
    assign bus.cell_x    = x_q;
    assign bus.cell_y    = y_q;
    assign bus.cell_idx  = idx_q;
    assign bus.last_cell = last_q;
    assign bus.gen_done  = done_q;
    assign bus.gen_cnt   = gen_q;
    assign bus.running   = running_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl
// Bench for life_gen_ctrl with a 3x2 grid and a 2-bit generation counter.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_life_gen_ctrl;
    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;

    life_gen_ctrl_if #(.LOG2X(2), .LOG2Y(1), .GEN_W(2), .PER_W(8)) bus ();

    life_gen_ctrl #(
        .X(3), .Y(2), .LOG2X(2), .LOG2Y(1), .GEN_W(2), .PER_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic        nxt;
        logic        run;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[18];

    // {sweep_en, cell_x, cell_y, cell_idx, last_cell, gen_done, gen_cnt, running}
    function automatic logic [11:0] pk(input logic en, input int x, input int y,
                                       input int idx, input logic last,
                                       input logic done, input int gen,
                                       input logic run);
        logic [1:0] xv, gv;
        logic [2:0] iv;
        logic       yv;
        xv = x[1:0];
        yv = y[0];
        iv = idx[2:0];
        gv = gen[1:0];
        return {en, xv, yv, iv, last, done, gv, run};
    endfunction

    function automatic logic [11:0] outs();
        return {bus.sweep_en, bus.cell_x, bus.cell_y, bus.cell_idx,
                bus.last_cell, bus.gen_done, bus.gen_cnt, bus.running};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic cyc(input logic n, input logic r);
        bus.key_nxt = n;
        bus.key_run = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic k);
        bus.key_nxt = k;
        bus.key_run = k;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Cycles (keys idle) until sweep_en equals want; n = cycles taken.
    task automatic wait_en(input logic want, input int budget, output int n);
        n = 0;
        while (bus.sweep_en !== want && n < budget) begin
            cyc(1'b0, 1'b0);
            n++;
        end
    endtask

    task automatic count_en(input int cycles, output int n_en, output int n_done);
        n_en = 0;
        n_done = 0;
        for (int i = 0; i < cycles; i++) begin
            cyc(1'b0, 1'b0);
            if (bus.sweep_en === 1'b1) n_en++;
            if (bus.gen_done === 1'b1) n_done++;
        end
    endtask

    initial begin
        int n, ne, nd;
        logic [11:0] e;

        bus.period  = '0;
        bus.key_nxt = 1'b0;
        bus.key_run = 1'b0;
        reset       = 1'b1;

        // Reset state, keys held high during reset so that a cleared key
        // delay register must not turn the post-reset drop into a release.
        do_reset(1'b1);
        chk("reset_outs", 32'(outs()), 32'(0));
        chk("reset_state", 32'(state_dbg), 32'(0));
        cyc(1'b0, 1'b0);
        chk("reset_no_release", 32'(outs()), 32'(0));

        // Table: single step sweep, then run on / off mid-sweep.
        vecs[0]  = '{1'b1, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b0, 1'b0, pk(1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{1'b0, 1'b0, pk(1, 1, 0, 1, 0, 0, 0, 0)};
        vecs[3]  = '{1'b0, 1'b0, pk(1, 2, 0, 2, 0, 0, 0, 0)};
        vecs[4]  = '{1'b0, 1'b0, pk(1, 0, 1, 3, 0, 0, 0, 0)};
        vecs[5]  = '{1'b0, 1'b0, pk(1, 1, 1, 4, 0, 0, 0, 0)};
        vecs[6]  = '{1'b0, 1'b0, pk(1, 2, 1, 5, 1, 0, 0, 0)};
        vecs[7]  = '{1'b0, 1'b0, pk(0, 0, 0, 0, 0, 1, 1, 0)};
        vecs[8]  = '{1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 1, 0)};
        vecs[9]  = '{1'b0, 1'b1, pk(0, 0, 0, 0, 0, 0, 1, 0)};
        vecs[10] = '{1'b0, 1'b0, pk(1, 0, 0, 0, 0, 0, 1, 1)};
        vecs[11] = '{1'b0, 1'b1, pk(1, 1, 0, 1, 0, 0, 1, 1)};
        vecs[12] = '{1'b0, 1'b0, pk(1, 2, 0, 2, 0, 0, 1, 0)};
        vecs[13] = '{1'b0, 1'b0, pk(1, 0, 1, 3, 0, 0, 1, 0)};
        vecs[14] = '{1'b0, 1'b0, pk(1, 1, 1, 4, 0, 0, 1, 0)};
        vecs[15] = '{1'b0, 1'b0, pk(1, 2, 1, 5, 1, 0, 1, 0)};
        vecs[16] = '{1'b0, 1'b0, pk(0, 0, 0, 0, 0, 1, 2, 0)};
        vecs[17] = '{1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 2, 0)};
        for (int i = 0; i < 18; i++) exp_q.push_back(vecs[i].exp);
        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].nxt, vecs[i].run);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(e));
        end

        // Three step releases during a sweep -> exactly one extra sweep.
        do_reset(1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        chk("pend_done", 32'({bus.gen_done, bus.gen_cnt}), 32'({1'b1, 2'd1}));
        cyc(1'b0, 1'b0);
        chk("pend_restart", 32'({bus.sweep_en, bus.cell_idx}), 32'({1'b1, 3'd0}));
        wait_en(1'b0, 20, n);
        chk("pend_len", 32'(n), 32'(6));
        chk("pend_gen", 32'(bus.gen_cnt), 32'(2));
        count_en(15, ne, nd);
        chk("pend_no_third", 32'(ne), 32'(0));

        // Run mode, period=4; step releases ignored; stop in WAIT.
        do_reset(1'b0);
        bus.period = 8'd4;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("run4_start", 32'({bus.running, bus.sweep_en}), 32'(2'b11));
        wait_en(1'b0, 20, n);
        chk("run4_len", 32'(n), 32'(6));
        wait_en(1'b1, 20, n);
        chk("run4_gap1", 32'(n), 32'(5));
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        wait_en(1'b0, 20, n);
        chk("run4_len_step", 32'(n), 32'(4));
        wait_en(1'b1, 20, n);
        chk("run4_gap2", 32'(n), 32'(5));
        wait_en(1'b0, 20, n);
        chk("run4_done", 32'(bus.gen_done), 32'(1));
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("run4_stop", 32'({bus.running, state_dbg}), 32'(0));
        count_en(20, ne, nd);
        chk("run4_idle", 32'(ne), 32'(0));

        // Run mode, period=0; stop mid-sweep lets the sweep finish.
        do_reset(1'b0);
        bus.period = 8'd0;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        wait_en(1'b0, 20, n);
        wait_en(1'b1, 20, n);
        chk("run0_gap1", 32'(n), 32'(1));
        wait_en(1'b0, 20, n);
        chk("run0_len", 32'(n), 32'(6));
        wait_en(1'b1, 20, n);
        chk("run0_gap2", 32'(n), 32'(1));
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("run0_off_mid", 32'({bus.running, bus.sweep_en}), 32'(2'b01));
        wait_en(1'b0, 20, n);
        chk("run0_finish", 32'(n), 32'(4));
        count_en(15, ne, nd);
        chk("run0_idle", 32'(ne), 32'(0));

        // 2-bit generation counter wrap, then reset mid-sweep.
        do_reset(1'b0);
        for (int g = 1; g <= 5; g++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
            for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
            if (g <= 4) chk($sformatf("wrap_gen%0d", g), 32'(bus.gen_cnt), 32'(g % 4));
        end
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("mid_pre", 32'({bus.sweep_en, bus.cell_idx, bus.gen_cnt}),
            32'({1'b1, 3'd2, 2'd1}));
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("mid_reset_outs", 32'(outs()), 32'(0));
        count_en(12, ne, nd);
        chk("mid_reset_quiet", 32'({ne[7:0], nd[7:0]}), 32'(0));

        // Simultaneous step and run releases in IDLE.
        do_reset(1'b0);
        bus.period = 8'd2;
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("both_start", 32'({bus.running, bus.sweep_en}), 32'(2'b11));
        wait_en(1'b0, 20, n);
        wait_en(1'b1, 20, n);
        chk("both_gap", 32'(n), 32'(3));
        wait_en(1'b0, 20, n);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("both_stop", 32'({bus.running, state_dbg}), 32'(0));
        count_en(15, ne, nd);
        chk("both_no_pending", 32'(ne), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
